seq_pattern_detect: RTL and testbench

//  Runtime-programmable serial bit-pattern detector, successor to the fixed 5-bit FSM detectors.

---
 rtl/seq_pattern_detect_pkg.sv | 15 +
 rtl/sat_counter.sv | 43 ++++
 rtl/seq_pattern_detect.sv | 120 ++++++++++++
 tb/tb_seq_pattern_detect.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/seq_pattern_detect_pkg.sv
// Shared defaults and width helper for the programmable serial pattern detector.
package seq_pattern_detect_pkg;

  localparam int unsigned DefMaxLen  = 8;
  localparam int unsigned DefCntW    = 8;
  localparam logic [7:0]  DefPattern = 8'b0001_1011;
  localparam int unsigned DefLen     = 5;
  localparam bit          DefOverlap = 1'b1;

  // Width able to hold every value 0..max_len.
  function automatic int unsigned len_w(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a sticky flag raised once the count reaches all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (clr) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else begin
      if (inc && !(&cnt_q)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      sat_d = sat_q | (&cnt_d);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign cnt = cnt_q;
  assign sat = sat_q;

endmodule

// File: rtl/seq_pattern_detect.sv
// Runtime-programmable serial bit-pattern detector with registered match pulse
// and a saturating match counter.
module seq_pattern_detect
  import seq_pattern_detect_pkg::*;
#(
  parameter int unsigned          MAX_LEN     = DefMaxLen,
  parameter int unsigned          CNT_W       = DefCntW,
  parameter logic [MAX_LEN-1:0]   DEF_PATTERN = MAX_LEN'(DefPattern),
  parameter int unsigned          DEF_LEN     = DefLen,
  parameter bit                   DEF_OVERLAP = DefOverlap,
  localparam int unsigned         LEN_W       = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               din,
  input  logic               din_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cnt_sat
);

  localparam logic [LEN_W-1:0] MaxLenW = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] DefLenW = LEN_W'(DEF_LEN);

  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               overlap_q, overlap_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               match_q, match_d;

  logic [LEN_W-1:0]   len_clamped;
  logic [MAX_LEN-1:0] nhist;
  logic [LEN_W-1:0]   nfill;
  logic [MAX_LEN-1:0] len_mask;
  logic               hit;

  always_comb begin
    len_clamped = cfg_len;
    if (cfg_len == '0) begin
      len_clamped = LEN_W'(1);
    end else if (cfg_len > MaxLenW) begin
      len_clamped = MaxLenW;
    end
  end

  // Only the low len_q bits of history and pattern take part in the compare.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      len_mask[i] = (int'(len_q) > i);
    end
  end

  assign nhist = {hist_q[MAX_LEN-2:0], din};
  assign nfill = (fill_q == MaxLenW) ? fill_q : fill_q + LEN_W'(1);
  assign hit   = din_valid && !cfg_load && (nfill >= len_q) &&
                 (((nhist ^ pattern_q) & len_mask) == '0);

  always_comb begin
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    match_d   = 1'b0;
    if (cfg_load) begin
      pattern_d = cfg_pattern;
      len_d     = len_clamped;
      overlap_d = cfg_overlap;
      hist_d    = '0;
      fill_d    = '0;
    end else if (din_valid) begin
      match_d = hit;
      if (hit && !overlap_q) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = nhist;
        fill_d = nfill;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pattern_q <= DEF_PATTERN;
      len_q     <= DefLenW;
      overlap_q <= DEF_OVERLAP;
      hist_q    <= '0;
      fill_q    <= '0;
      match_q   <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cfg_load),
    .inc   (hit),
    .cnt   (match_cnt),
    .sat   (cnt_sat)
  );

  assign match = match_q;

endmodule

// File: tb/tb_seq_pattern_detect.sv
// Directed bench for seq_pattern_detect: a default-width instance and a 2-bit counter instance
// share one stimulus stream.
module tb_seq_pattern_detect;

  logic       clk = 1'b0;
  logic       reset;
  logic       din;
  logic       din_valid;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;

  logic       match_a, cnt_sat_a;
  logic [7:0] match_cnt_a;
  logic       match_b, cnt_sat_b;
  logic [1:0] match_cnt_b;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_pattern_detect dut_a (
    .clk         (clk),
    .reset       (reset),
    .din         (din),
    .din_valid   (din_valid),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .match       (match_a),
    .match_cnt   (match_cnt_a),
    .cnt_sat     (cnt_sat_a)
  );

  seq_pattern_detect #(
    .CNT_W (2)
  ) dut_b (
    .clk         (clk),
    .reset       (reset),
    .din         (din),
    .din_valid   (din_valid),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .match       (match_b),
    .match_cnt   (match_cnt_b),
    .cnt_sat     (cnt_sat_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic drive(input logic d, input logic v);
    din       = d;
    din_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic ov,
                      input logic d, input logic v);
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = ov;
    cfg_load    = 1'b1;
    drive(d, v);
    cfg_load  = 1'b0;
    din_valid = 1'b0;
  endtask

  // Sends n bits MSB first and checks match after each sampling edge.
  task automatic send_bits(input string tag, input logic [15:0] bits, input int n,
                           input logic [15:0] exp_match);
    for (int i = n - 1; i >= 0; i--) begin
      drive(bits[i], 1'b1);
      check(tag, 32'(match_a), 32'(exp_match[i]));
    end
  endtask

  initial begin
    reset       = 1'b1;
    din         = 1'b0;
    din_valid   = 1'b0;
    cfg_load    = 1'b0;
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_overlap = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_match", 32'(match_a), 32'd0);
    check("reset_cnt", 32'(match_cnt_a), 32'd0);
    check("reset_sat", 32'(cnt_sat_a), 32'd0);

    // 1: defaults, overlapping
    send_bits("t1_match", 16'b1101_1011, 8, 16'b0000_1001);
    check("t1_cnt", 32'(match_cnt_a), 32'd2);

    // 2: non-overlapping
    load(8'b0001_1011, 4'd5, 1'b0, 1'b0, 1'b0);
    check("t2_cnt_clr", 32'(match_cnt_a), 32'd0);
    send_bits("t2_match", 16'b1101_1011, 8, 16'b0000_1000);
    check("t2_cnt", 32'(match_cnt_a), 32'd1);

    // 3: three bubbles between bits
    load(8'b0001_1011, 4'd5, 1'b1, 1'b0, 1'b0);
    for (int b = 4; b >= 0; b--) begin
      drive(b != 2, 1'b1);
      check("t3_bit", 32'(match_a), (b == 0) ? 32'd1 : 32'd0);
      for (int k = 0; k < 3; k++) begin
        drive(1'b1, 1'b0);
        check("t3_bubble", 32'(match_a), 32'd0);
      end
    end
    check("t3_cnt", 32'(match_cnt_a), 32'd1);

    // 4: reload mid-stream, load cycle's din dropped; upper pattern bits ignored
    send_bits("t4_pre", 16'b11, 2, 16'b00);
    load(8'b1111_0101, 4'd3, 1'b1, 1'b1, 1'b1);
    check("t4_load_match", 32'(match_a), 32'd0);
    check("t4_load_cnt", 32'(match_cnt_a), 32'd0);
    send_bits("t4_match", 16'b101, 3, 16'b001);
    check("t4_cnt", 32'(match_cnt_a), 32'd1);
    send_bits("t4_ovl", 16'b01, 2, 16'b01);
    check("t4_cnt_ovl", 32'(match_cnt_a), 32'd2);

    // 5: len 0 clamps to 1; 2-bit counter saturates
    load(8'b0000_0001, 4'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 1'b1);
      check("t5_match_a", 32'(match_a), 32'd1);
      check("t5_match_b", 32'(match_b), 32'd1);
      check("t5_cnt_b", 32'(match_cnt_b), (i < 3) ? 32'(i) : 32'd3);
      check("t5_sat_b", 32'(cnt_sat_b), (i >= 3) ? 32'd1 : 32'd0);
    end
    check("t5_cnt_a", 32'(match_cnt_a), 32'd5);
    check("t5_sat_a", 32'(cnt_sat_a), 32'd0);
    drive(1'b1, 1'b0);
    check("t5_bubble", 32'(match_a), 32'd0);

    // 6: reset mid-pattern restores defaults and drops history
    load(8'b0000_0111, 4'd3, 1'b0, 1'b0, 1'b0);
    send_bits("t6_pre", 16'b1101, 4, 16'b0000);
    reset = 1'b1;
    drive(1'b1, 1'b1);
    reset = 1'b0;
    check("t6_rst_match", 32'(match_a), 32'd0);
    check("t6_rst_cnt", 32'(match_cnt_a), 32'd0);
    check("t6_rst_sat_b", 32'(cnt_sat_b), 32'd0);
    send_bits("t6_match", 16'b1_1011, 5, 16'b0_0001);
    check("t6_cnt", 32'(match_cnt_a), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
